// File: rtl/wash_panel_ctrl.sv
// Washing-machine front-panel controller.
// Debounces the panel buttons, cycles the program selection, issues the
// one-cycle start strobe, holds the door lock while a program runs, detects
// completion, supervises the run with a watchdog and drives the BCD display.
// Optional build macro: PANEL_CHILD_LOCK_EN adds a child_lock input that
// blocks mode/start (and cancel outside FAULT) while it is asserted.
module wash_panel_ctrl #(
    parameter int DB_CYCLES    = 4,
    parameter int BUZZ_CYCLES  = 20,
    parameter int ABORT_CYCLES = 3,
    parameter int RUN_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_cancel,
`ifdef PANEL_CHILD_LOCK_EN
    input  logic       child_lock,
`endif
    input  logic       door_closed,
    input  logic       program_done,
    input  logic       soap_warning,
    input  logic [7:0] timer_display,
    output logic [2:0] program_selection,
    output logic       start,
    output logic       fsm_abort,
    output logic       door_lock,
    output logic       buzzer,
    output logic       door_warn,
    output logic       soap_led,
    output logic       fault_led,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    localparam int DB_W = (DB_CYCLES    > 1) ? $clog2(DB_CYCLES)    : 1;
    localparam int BZ_W = (BUZZ_CYCLES  > 1) ? $clog2(BUZZ_CYCLES)  : 1;
    localparam int AB_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam int WD_W = (RUN_TIMEOUT  > 1) ? $clog2(RUN_TIMEOUT)  : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [BZ_W-1:0] BZ_LAST = BZ_W'(BUZZ_CYCLES - 1);
    localparam logic [AB_W-1:0] AB_LAST = AB_W'(ABORT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ABORT = 3'd2,
        ST_FAULT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = mode, 1 = start, 2 = cancel
    // ------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] press_evt;

    assign btn_raw = {btn_cancel, btn_start, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            level_d_reg;
            logic [DB_W-1:0] cnt_reg;

            // Synchronise, then accept a new level only after DB_CYCLES
            // consecutive samples that disagree with the current level.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            // One-cycle press event on the debounced rising level.
            assign press_evt[gi] = level_reg & ~level_d_reg;
        end
    endgenerate

    logic mode_evt;
    logic start_evt;
    logic cancel_evt;
    logic cancel_fault_evt;

`ifdef PANEL_CHILD_LOCK_EN
    logic cl_sync1_reg;
    logic cl_sync2_reg;

    // Two-flop synchroniser for the child-lock switch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cl_sync1_reg <= 1'b0;
            cl_sync2_reg <= 1'b0;
        end else begin
            cl_sync1_reg <= child_lock;
            cl_sync2_reg <= cl_sync1_reg;
        end
    end

    assign mode_evt   = press_evt[0] & ~cl_sync2_reg;
    assign start_evt  = press_evt[1] & ~cl_sync2_reg;
    assign cancel_evt = press_evt[2] & ~cl_sync2_reg;
`else
    assign mode_evt   = press_evt[0];
    assign start_evt  = press_evt[1];
    assign cancel_evt = press_evt[2];
`endif
    // Leaving FAULT is always possible, even with the child lock on.
    assign cancel_fault_evt = press_evt[2];

    // ------------------------------------------------------------------
    // program_done edge detection and soap LED
    // ------------------------------------------------------------------
    logic done_d_reg;
    logic done_rise_reg;
    logic soap_reg;

    // Registered rising-edge detect of program_done; soap_led follows input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_d_reg    <= 1'b0;
            done_rise_reg <= 1'b0;
            soap_reg      <= 1'b0;
        end else begin
            done_d_reg    <= program_done;
            done_rise_reg <= program_done & ~done_d_reg;
            soap_reg      <= soap_warning;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [1:0]      sel_reg, sel_next;
    logic            start_reg, start_next;
    logic            warn_reg, warn_next;
    logic            fault_reg, fault_next;
    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic [AB_W-1:0] abort_cnt_reg, abort_cnt_next;
    logic [BZ_W-1:0] buzz_cnt_reg, buzz_cnt_next;
    logic            done_hit;

    // An edge registered during the entry cycle happened before RUN began,
    // so it is only honoured once the watchdog has moved off zero.
    assign done_hit = done_rise_reg && (wd_cnt_reg != '0);

    // State and control register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= 2'd0;
            start_reg     <= 1'b0;
            warn_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            wd_cnt_reg    <= '0;
            abort_cnt_reg <= '0;
            buzz_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            start_reg     <= start_next;
            warn_reg      <= warn_next;
            fault_reg     <= fault_next;
            wd_cnt_reg    <= wd_cnt_next;
            abort_cnt_reg <= abort_cnt_next;
            buzz_cnt_reg  <= buzz_cnt_next;
        end
    end

    // Next-state logic; counters reset to zero whenever their state is left.
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        start_next     = 1'b0;
        warn_next      = warn_reg;
        fault_next     = fault_reg;
        wd_cnt_next    = '0;
        abort_cnt_next = '0;
        buzz_cnt_next  = '0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (mode_evt) begin
                    sel_next  = sel_reg + 2'd1;
                    warn_next = 1'b0;
                end
                if (state_reg == ST_DONE) begin
                    buzz_cnt_next = buzz_cnt_reg + BZ_W'(1);
                    if (cancel_evt || (buzz_cnt_reg == BZ_LAST)) begin
                        state_next = ST_IDLE;
                    end
                end
                if (start_evt) begin
                    if (door_closed) begin
                        state_next = ST_RUN;
                        start_next = 1'b1;
                        warn_next  = 1'b0;
                    end else begin
                        warn_next = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                wd_cnt_next = wd_cnt_reg + WD_W'(1);
                if (done_hit) begin
                    state_next = ST_DONE;
                end else if (cancel_evt) begin
                    state_next = ST_ABORT;
                end else if (wd_cnt_reg == WD_LAST) begin
                    state_next = ST_ABORT;
                    fault_next = 1'b1;
                end
            end

            ST_ABORT: begin
                abort_cnt_next = abort_cnt_reg + AB_W'(1);
                if (abort_cnt_reg == AB_LAST) begin
                    state_next = fault_reg ? ST_FAULT : ST_IDLE;
                end
            end

            ST_FAULT: begin
                if (cancel_fault_evt) begin
                    state_next = ST_IDLE;
                    fault_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timer to BCD (shift-and-add-3), registered
    // ------------------------------------------------------------------
    logic [19:0] dd_work;
    logic [3:0]  hund_reg, tens_reg, ones_reg;

    // Double-dabble conversion of the 8-bit timer value.
    always_comb begin
        dd_work = {12'd0, timer_display};
        for (int i = 0; i < 8; i++) begin
            if (dd_work[11:8]  >= 4'd5) dd_work[11:8]  = dd_work[11:8]  + 4'd3;
            if (dd_work[15:12] >= 4'd5) dd_work[15:12] = dd_work[15:12] + 4'd3;
            if (dd_work[19:16] >= 4'd5) dd_work[19:16] = dd_work[19:16] + 4'd3;
            dd_work = {dd_work[18:0], 1'b0};
        end
    end

    // Display digit registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hund_reg <= 4'd0;
            tens_reg <= 4'd0;
            ones_reg <= 4'd0;
        end else begin
            hund_reg <= dd_work[19:16];
            tens_reg <= dd_work[15:12];
            ones_reg <= dd_work[11:8];
        end
    end

    // ------------------------------------------------------------------
    // Outputs: lock, abort and buzzer decode straight from the state so
    // that reset drops them immediately.
    // ------------------------------------------------------------------
    assign program_selection = {1'b0, sel_reg};
    assign start             = start_reg;
    assign fsm_abort         = (state_reg == ST_ABORT);
    assign door_lock         = (state_reg == ST_RUN) || (state_reg == ST_ABORT);
    assign buzzer            = (state_reg == ST_DONE);
    assign door_warn         = warn_reg;
    assign soap_led          = soap_reg;
    assign fault_led         = fault_reg;
    assign bcd_hund          = hund_reg;
    assign bcd_tens          = tens_reg;
    assign bcd_ones          = ones_reg;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl (RUN_TIMEOUT shortened to 64).
module tb_wash_panel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_cancel = 1'b0;
    logic       door_closed = 1'b0;
    logic       program_done = 1'b0;
    logic       soap_warning = 1'b0;
    logic [7:0] timer_display = 8'd0;
    logic [2:0] program_selection;
    logic       start, fsm_abort, door_lock, buzzer, door_warn, soap_led, fault_led;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;

    wash_panel_ctrl #(
        .DB_CYCLES(4), .BUZZ_CYCLES(20), .ABORT_CYCLES(3), .RUN_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_start(btn_start), .btn_cancel(btn_cancel),
        .door_closed(door_closed), .program_done(program_done),
        .soap_warning(soap_warning), .timer_display(timer_display),
        .program_selection(program_selection), .start(start),
        .fsm_abort(fsm_abort), .door_lock(door_lock), .buzzer(buzzer),
        .door_warn(door_warn), .soap_led(soap_led), .fault_led(fault_led),
        .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor: pulse widths, counts and cycle stamps.
    int cyc = 0;
    int start_count = 0, start_run = 0, max_start_run = 0, start_cyc = 0;
    int lock_at_start = 0, overlap = 0;
    int abort_run = 0, last_abort_len = 0, abort_count = 0, abort_rise_cyc = 0;
    int abort_lock_bad = 0;
    int buzz_run = 0, last_buzz_len = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start) begin
            start_count   <= start_count + 1;
            lock_at_start <= int'(door_lock);
            start_cyc     <= cyc;
            if (start_run + 1 > max_start_run) max_start_run <= start_run + 1;
        end
        start_run <= start ? start_run + 1 : 0;
        if (start && fsm_abort) overlap <= overlap + 1;
        if (fsm_abort) begin
            abort_run <= abort_run + 1;
            if (abort_run == 0) abort_rise_cyc <= cyc;
            if (!door_lock) abort_lock_bad <= abort_lock_bad + 1;
        end else if (abort_run != 0) begin
            last_abort_len <= abort_run;
            abort_count    <= abort_count + 1;
            abort_run      <= 0;
        end
        if (buzzer) buzz_run <= buzz_run + 1;
        else if (buzz_run != 0) begin
            last_buzz_len <= buzz_run;
            buzz_run      <= 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_mode = v;
            1: btn_start = v;
            default: btn_cancel = v;
        endcase
    endtask

    // Hold a button, release it and let the release debounce out.
    task automatic press(input int idx, input int hold);
        set_btn(idx, 1'b1);
        step(hold);
        set_btn(idx, 1'b0);
        step(12);
    endtask

    typedef struct {
        logic [7:0] tval;
        int         hund;
        int         tens;
        int         ones;
    } bcd_vec_t;

    bcd_vec_t bcd_tab[8];
    int       mode_exp[4];
    int       sc;
    int       ac;

    initial begin
        bcd_tab[0] = '{8'd0,   0, 0, 0};
        bcd_tab[1] = '{8'd9,   0, 0, 9};
        bcd_tab[2] = '{8'd10,  0, 1, 0};
        bcd_tab[3] = '{8'd99,  0, 9, 9};
        bcd_tab[4] = '{8'd100, 1, 0, 0};
        bcd_tab[5] = '{8'd255, 2, 5, 5};
        bcd_tab[6] = '{8'd199, 1, 9, 9};
        bcd_tab[7] = '{8'd57,  0, 5, 7};
        mode_exp   = '{1, 2, 3, 0};

        // Reset state
        #2 rst = 1'b0;
        step(3);
        check("rst_sel", int'(program_selection), 0);
        check("rst_start", int'(start), 0);
        check("rst_abort", int'(fsm_abort), 0);
        check("rst_lock", int'(door_lock), 0);
        check("rst_buzzer", int'(buzzer), 0);
        check("rst_warn", int'(door_warn), 0);
        check("rst_fault", int'(fault_led), 0);
        check("rst_soap", int'(soap_led), 0);
        rst = 1'b1;
        step(2);

        // 1. Program selection cycling
        for (int i = 0; i < 4; i++) begin
            press(0, 10);
            check($sformatf("mode_press_%0d", i + 1), int'(program_selection), mode_exp[i]);
        end

        // 2. Normal run to completion
        door_closed = 1'b1;
        sc = start_count;
        press(1, 10);
        check("run_start_count", start_count, sc + 1);
        check("run_lock_with_start", lock_at_start, 1);
        check("run_lock", int'(door_lock), 1);
        check("run_start_low", int'(start), 0);
        program_done = 1'b1;
        step(1);
        program_done = 1'b0;
        step(3);
        check("done_buzzer_on", int'(buzzer), 1);
        check("done_lock_off", int'(door_lock), 0);
        step(30);
        check("done_buzz_len", last_buzz_len, 20);
        check("done_buzzer_off", int'(buzzer), 0);
        press(0, 10);
        check("idle_after_done_mode", int'(program_selection), 1);

        // 3. Start with door open is refused
        door_closed = 1'b0;
        sc = start_count;
        press(1, 10);
        check("open_no_start", start_count, sc);
        check("open_warn", int'(door_warn), 1);
        check("open_lock", int'(door_lock), 0);
        door_closed = 1'b1;
        press(1, 10);
        check("closed_warn_clear", int'(door_warn), 0);
        check("closed_start", start_count, sc + 1);
        check("closed_lock", int'(door_lock), 1);
        press(0, 10);
        check("run_mode_ignored", int'(program_selection), 1);

        // 4. Cancel during RUN, then re-entry with program_done already high
        ac = abort_count;
        press(2, 10);
        check("cancel_abort_count", abort_count, ac + 1);
        check("cancel_abort_len", last_abort_len, 3);
        check("cancel_lock_off", int'(door_lock), 0);
        check("cancel_no_fault", int'(fault_led), 0);
        program_done = 1'b1;
        step(5);
        press(1, 10);
        step(10);
        check("held_done_still_run", int'(door_lock), 1);
        check("held_done_no_buzz", int'(buzzer), 0);
        press(2, 10);
        program_done = 1'b0;
        check("held_done_exit_lock", int'(door_lock), 0);

        // 5. Watchdog timeout
        sc = start_count;
        press(1, 10);
        check("wd_start", start_count, sc + 1);
        step(70);
        check("wd_abort_cycle", abort_rise_cyc - start_cyc, 64);
        check("wd_abort_len", last_abort_len, 3);
        check("wd_fault_led", int'(fault_led), 1);
        check("wd_lock_off", int'(door_lock), 0);
        sc = start_count;
        press(1, 10);
        check("fault_start_ignored", start_count, sc);
        check("fault_lock", int'(door_lock), 0);
        press(0, 10);
        check("fault_mode_ignored", int'(program_selection), 1);
        press(2, 10);
        check("fault_cleared", int'(fault_led), 0);
        press(0, 10);
        check("idle_after_fault_mode", int'(program_selection), 2);

        // 6. BCD sweep, one cycle latency
        for (int i = 0; i < 8; i++) begin
            timer_display = bcd_tab[i].tval;
            step(1);
            check($sformatf("bcd_%0d_hund", bcd_tab[i].tval), int'(bcd_hund), bcd_tab[i].hund);
            check($sformatf("bcd_%0d_tens", bcd_tab[i].tval), int'(bcd_tens), bcd_tab[i].tens);
            check($sformatf("bcd_%0d_ones", bcd_tab[i].tval), int'(bcd_ones), bcd_tab[i].ones);
        end

        // Short glitch produces no mode event
        btn_mode = 1'b1;
        step(2);
        btn_mode = 1'b0;
        step(12);
        check("glitch_no_event", int'(program_selection), 2);

        // soap_led is a one-cycle delayed copy
        soap_warning = 1'b1;
        #1;
        check("soap_not_yet", int'(soap_led), 0);
        step(1);
        check("soap_on", int'(soap_led), 1);
        soap_warning = 1'b0;
        step(1);
        check("soap_off", int'(soap_led), 0);

        // Asynchronous reset in the middle of a run
        press(1, 10);
        check("arst_pre_lock", int'(door_lock), 1);
        #3 rst = 1'b0;
        #1;
        check("arst_lock_drop", int'(door_lock), 0);
        check("arst_sel_clear", int'(program_selection), 0);
        step(2);
        rst = 1'b1;
        step(2);

        // Global strobe properties
        check("start_max_width", max_start_run, 1);
        check("start_abort_overlap", overlap, 0);
        check("abort_lock_held", abort_lock_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
- Front-panel controller that drives the washing-machine FSM's command inputs and consumes its status outputs.
- Debounces the user buttons, cycles the program selection and issues a single-cycle start strobe.
- Holds the door lock while a program runs, detects completion, and runs a watchdog with abort.
- Converts the FSM's 8-bit timer to BCD for the display; sits between the board I/O and the FSM.

Parameters:
- DB_CYCLES, 4: consecutive identical samples required before a button level is accepted.
- BUZZ_CYCLES, 20: buzzer on-time after program completion.
- ABORT_CYCLES, 3: length of the fsm_abort pulse.
- RUN_TIMEOUT, 4096: cycles allowed in RUN without a program_done rising edge.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous active-low reset.
- btn_mode, in, 1: raw program-select button, active-high.
- btn_start, in, 1: raw start button.
- btn_cancel, in, 1: raw cancel button.
- door_closed, in, 1: door sensor, 1 = closed.
- program_done, in, 1: from FSM.
- soap_warning, in, 1: from FSM.
- timer_display, in, 8: from FSM, remaining time.
- program_selection, out, 3: to FSM.
- start, out, 1: one-cycle start strobe to FSM.
- fsm_abort, out, 1: abort request to FSM reset logic.
- door_lock, out, 1: door latch solenoid.
- buzzer, out, 1: completion buzzer.
- door_warn, out, 1: start was refused because the door is open.
- soap_led, out, 1: registered copy of soap_warning.
- fault_led, out, 1: watchdog fault.
- bcd_hund, out, 4: BCD hundreds digit of the timer.
- bcd_tens, out, 4: BCD tens digit of the timer.
- bcd_ones, out, 4: BCD ones digit of the timer.

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- All outputs are 0; program_selection=3'b000.
- Debounce counters and edge registers are cleared.
- Reset mid-run immediately drops door_lock.

Debounce:
- Each button is synchronised through 2 flops.
- The debounced level changes only after DB_CYCLES consecutive equal synchronised samples.
- A press event is a 0->1 transition of the debounced level, one cycle wide.
- Press-to-event latency: 2+DB_CYCLES cycles.

Program selection:
- A mode event in IDLE or DONE cycles 000->001->010->011->000.
- Mode events are ignored in all other states.
- Values 1xx are never driven.

States:
- IDLE:
  - start event with door_closed=1: start=1 for exactly the next cycle, door_lock=1, go to RUN, clear door_warn.
  - start event with door_closed=0: door_warn=1, stay in IDLE. door_warn clears on the next mode or start event.
- RUN:
  - door_lock=1.
  - Watchdog counts from 0 at entry.
  - Detect the rising edge of program_done, registered one cycle. A level that is already high at entry is ignored.
  - program_done rising edge: go to DONE, buzzer=1 for BUZZ_CYCLES cycles, door_lock=0.
  - cancel event: go to ABORT.
  - Watchdog reaches RUN_TIMEOUT-1 without done: go to ABORT with fault_led=1.
  - Same-cycle done and cancel: done wins.
- ABORT:
  - fsm_abort=1 for ABORT_CYCLES cycles, door_lock stays 1.
  - Afterwards, door_lock=0 and go to FAULT if fault_led=1, otherwise IDLE.
- FAULT:
  - fault_led=1; all events except cancel are ignored.
  - cancel event: fault_led=0, go to IDLE.
- DONE:
  - buzzer counts down; mode is allowed.
  - start event behaves exactly as in IDLE.
  - cancel event or buzzer expiry: buzzer=0, go to IDLE.

Other rules:
- start is never asserted for more than 1 cycle.
- start and fsm_abort are never asserted in the same cycle.
- soap_led is soap_warning delayed one cycle, in every state.

BCD:
- Registered conversion of timer_display with 1-cycle latency.
- Range 0-255; bcd_hund max 2.
- Example: 8'd255 -> 2/5/5.

Optional Feature:
- Macro: PANEL_CHILD_LOCK_EN.
- Defined:
  - Adds input port child_lock (1 bit), synchronised with 2 flops.
  - While the synchronised child_lock=1, mode and start events are discarded in every state.
  - Cancel events are honoured only in FAULT; cancel in RUN is ignored.
  - Watchdog abort still operates.
- Undefined:
  - Port absent; behaviour exactly as above.

Test Plan:
1. Reset, then 3 mode presses held 10 cycles each -> program_selection=3'b011; a 4th press -> 3'b000.
2. door_closed=1, start press -> one-cycle start, door_lock=1 from the same cycle; program_done pulse -> buzzer high for 20 cycles, then IDLE with door_lock=0.
3. door_closed=0, start press -> no start strobe, door_warn=1, door_lock=0; close the door and press start -> door_warn=0, start strobe issued.
4. In RUN, cancel press -> fsm_abort high for exactly 3 cycles, then door_lock=0 and state IDLE; program_done held high from the previous run does not cause DONE on re-entry to RUN.
5. RUN_TIMEOUT=64, no program_done -> ABORT at cycle 64, then fault_led=1 and FAULT; start press ignored; cancel press -> IDLE, fault_led=0.
6. timer_display sweep 0, 9, 10, 99, 100, 255 -> BCD 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0, 2/5/5, one cycle later; 2-cycle button glitch -> no event.
